conv_sequencer: RTL
===================

# conv_sequencer

Job controller for the `conv` streaming convolution datapath. On a `start` pulse it holds `conv` in reset, then reads the feature and filter elements from two local buffers over a read port with a 1-cycle latency. It presents each element to `conv` for a fixed number of cycles, with features first and filters second. It writes every result `conv` emits into a result buffer and signals job completion. It sits between the host/buffer layer and `conv` and is the only block that drives `conv`'s inputs.

## Interface
Parameters:
- `FEAT_N`, 9: feature elements per job.
- `FILT_N`, 4: filter elements per job.
- `HOLD`, 2: cycles each element is held on the `conv` inputs. Must be at least 2.
- `RST_CYC`, 2: cycles `conv_rst` is held after `start`. Must be at least 2.
- `AW`, 4: address width of the feature, filter and result buffers.
- `MAX_OUT`, 16: result-buffer capacity. Must be at most 2^AW.
- `TIMEOUT`, 64: COLLECT cycles allowed before `err_timeout` is set.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: job request. Sampled only in IDLE.
- `stride_cfg` in 3: stride for the job.
- `pad_cfg` in 3: padding for the job.
- `busy` out 1: high from the `start` edge until the DONE cycle inclusive.
- `job_done` out 1: 1-cycle pulse in DONE.
- `err_overflow` out 1: sticky per job. Set when more than MAX_OUT results arrive.
- `err_timeout` out 1: sticky per job.
- `res_count` out AW+1: number of results written in the current or last job.
- `feat_rd` out 1: feature-buffer read enable.
- `feat_addr` out AW: feature-buffer read address.
- `feat_data` in 8: feature-buffer read data, valid the cycle after `feat_rd`.
- `filt_rd` out 1: filter-buffer read enable.
- `filt_addr` out AW: filter-buffer read address.
- `filt_data` in 8: filter-buffer read data, same timing as `feat_data`.
- `conv_rst` out 1: reset to `conv`.
- `conv_feature` out 8: feature input to `conv`.
- `conv_filter` out 8: filter input to `conv`.
- `conv_stride` out 3: stride to `conv`.
- `conv_pad` out 3: padding to `conv`.
- `conv_out` in 16: result from `conv`.
- `conv_done` in 1: result-valid strobe from `conv`.
- `conv_complete` in 1: all results emitted by `conv`.
- `res_we` out 1: result-buffer write enable.
- `res_addr` out AW: result-buffer write address.
- `res_data` out 16: result-buffer write data.

## Operation
States: IDLE, RESET, FEAT, FILT, COLLECT, DONE.

- **IDLE**
  - `conv_rst`=1, and `conv_feature`=`conv_filter`=0.
  - `start`=1 → RESET.
  - On that edge, latch `stride_cfg`/`pad_cfg` into `conv_stride`/`conv_pad`.
  - On that edge, clear `res_count` and both error flags.
- **RESET**
  - Lasts RST_CYC cycles with `conv_rst`=1.
  - Then → FEAT, and `conv_rst` falls on that edge.
- **FEAT**
  - FEAT_N slots of HOLD cycles each.
  - Slot k: `conv_feature`=featbuf[k] and `conv_filter`=0.
  - After the last slot → FILT.
- **FILT**
  - FILT_N slots of HOLD cycles each.
  - Slot j: `conv_filter`=filtbuf[j] and `conv_feature`=0.
  - After the last slot → COLLECT.
  - On that edge both `conv` data inputs go to 0.
- **Prefetch**
  - The read for the element presented in a slot is issued during the cycle two cycles before that slot begins.
  - Each buffer sees exactly one `*_rd` pulse per element.
  - Addresses are 0..FEAT_N-1 and 0..FILT_N-1, incrementing.
  - The read for filter 0 is issued inside the final FEAT slot, on the `filt` port.
  - Returned data is registered into `conv_feature`/`conv_filter` on the slot-start edge.
- **Result capture**
  - Active in FEAT, FILT and COLLECT.
  - On a cycle with `conv_done`=1 and `res_count`<MAX_OUT, the same cycle gives `res_we`=1, `res_addr`=`res_count`, `res_data`=`conv_out`.
  - `res_count` increments on that edge.
  - If `res_count`=MAX_OUT, the result is dropped and `err_overflow` is set.
  - `conv_done` in IDLE, RESET or DONE is ignored.
- **Completion**
  - `conv_complete` is latched once seen in FEAT, FILT or COLLECT.
  - In COLLECT: if the latch is set (or `conv_complete`=1 in the current cycle) → DONE.
  - If TIMEOUT COLLECT cycles elapse first, set `err_timeout` and → DONE.
  - A `conv_done` in the same cycle as `conv_complete` is still captured.
- **DONE**
  - One cycle: `job_done`=1, `busy`=1, `conv_rst`=1.
  - → IDLE.
  - `res_count` and the error flags hold until the next `start`.
- `start` outside IDLE is ignored, with no queueing.
- `rst` asserted at any time forces IDLE asynchronously, aborting the job. Buffer contents are untouched.

## Timing
- Reset values:
  - `conv_rst`=1.
  - All other outputs 0, including `busy`, `job_done`, `res_we`, `*_rd`, `res_count`, error flags, `conv_stride` and `conv_pad`.
- Let E0 be the edge that samples `start`.
  - `busy`=1 and `feat_rd`=1 (addr 0) during cycle E0–E1.
  - `conv_rst` falls and featbuf[0] is presented at E(RST_CYC).
- Feature k is presented from E(RST_CYC+k·HOLD).
- Filter j is presented from E(RST_CYC+(FEAT_N+j)·HOLD).
- COLLECT begins at E(RST_CYC+(FEAT_N+FILT_N)·HOLD).
- With default parameters:
  - feature 0 at E2
  - filter 0 at E20
  - COLLECT at E28
- The result write happens in the same cycle as `conv_done`, with no extra latency.
- `job_done` is asserted in the cycle after `conv_complete` is seen in COLLECT.
- Back-to-back jobs: a `start` held high during DONE is not accepted. The earliest accepted `start` is the cycle after DONE.

## Test plan
- **Default job.**
  - Stimulus: featbuf = 1,2,1,2,1,2,1,2,1; filtbuf = 2,1,2,1; stride 1, pad 1; `start` at E0.
  - Required: `conv_feature` sequence 1,2,… each held 2 cycles from E2; filters 2,1,2,1 from E20; `conv_filter`=0 throughout FEAT; `conv_rst` low from E2.
- **Read discipline.**
  - Stimulus: the default job.
  - Required: exactly 9 `feat_rd` and 4 `filt_rd` pulses.
  - Required: each pulse occurs 2 cycles before its element's slot, with addresses in order.
- **Result capture.**
  - Stimulus: a `conv` model emits 4 `conv_done` pulses (values 5, 6, 7, 8), then `conv_complete`.
  - Required: writes at addresses 0–3 with data 5, 6, 7, 8.
  - Required: `res_count`=4, `job_done` pulses once, `busy` falls after DONE.
- **Overflow and timeout.**
  - Stimulus 1: 17 `conv_done` pulses with MAX_OUT=16.
  - Required: 16 writes, then `err_overflow`=1.
  - Stimulus 2: `conv_complete` withheld.
  - Required: DONE after 64 COLLECT cycles with `err_timeout`=1.
- **Ignored and aborted jobs.**
  - Stimulus 1: `start` pulsed during FEAT.
  - Required: no effect.
  - Stimulus 2: `rst` asserted mid-FILT.
  - Required: immediate IDLE, `conv_rst`=1, outputs at reset values; a new job then runs cleanly.
- **Config latch.**
  - Stimulus: `stride_cfg`/`pad_cfg` changed after E0.
  - Required: `conv_stride`/`conv_pad` hold the values sampled at E0 until the next `start`.

Source files
------------

// File: rtl/conv_sequencer.sv
// Job controller for the conv datapath: resets conv, streams features then filters
// from 1-cycle-latency buffers with prefetch, captures results and reports completion.
module conv_sequencer #(
    parameter int FEAT_N  = 9,
    parameter int FILT_N  = 4,
    parameter int HOLD    = 2,
    parameter int RST_CYC = 2,
    parameter int AW      = 4,
    parameter int MAX_OUT = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    stride_cfg,
    input  logic [2:0]    pad_cfg,
    output logic          busy,
    output logic          job_done,
    output logic          err_overflow,
    output logic          err_timeout,
    output logic [AW:0]   res_count,
    output logic          feat_rd,
    output logic [AW-1:0] feat_addr,
    input  logic [7:0]    feat_data,
    output logic          filt_rd,
    output logic [AW-1:0] filt_addr,
    input  logic [7:0]    filt_data,
    output logic          conv_rst,
    output logic [7:0]    conv_feature,
    output logic [7:0]    conv_filter,
    output logic [2:0]    conv_stride,
    output logic [2:0]    conv_pad,
    input  logic [15:0]   conv_out,
    input  logic          conv_done,
    input  logic          conv_complete,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [15:0]   res_data
);

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_FEAT, S_FILT, S_COLLECT, S_DONE} state_t;
    localparam int CW = 16;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [7:0]    feature_q, feature_d;
    logic [7:0]    filter_q, filter_d;
    logic [2:0]    stride_q, stride_d;
    logic [2:0]    pad_q, pad_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;
    logic          cmpl_q, cmpl_d;
    logic          cap_active;

    assign cap_active = (state_q == S_FEAT) || (state_q == S_FILT) || (state_q == S_COLLECT);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            feature_q <= '0;
            filter_q  <= '0;
            stride_q  <= '0;
            pad_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            cmpl_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            feature_q <= feature_d;
            filter_q  <= filter_d;
            stride_q  <= stride_d;
            pad_q     <= pad_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            cmpl_q    <= cmpl_d;
        end
    end

    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        feature_d = feature_q;
        filter_d  = filter_q;
        stride_d  = stride_q;
        pad_d     = pad_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        cmpl_d    = cmpl_q;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                feature_d = '0;
                filter_d  = '0;
                if (start) begin
                    state_d  = S_RESET;
                    stride_d = stride_cfg;
                    pad_d    = pad_cfg;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    tmo_d    = 1'b0;
                    cmpl_d   = 1'b0;
                end
            end
            S_RESET: begin
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d   = S_FEAT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    feature_d = feat_data;
                end
            end
            S_FEAT: begin
                if (cnt_q == CW'(HOLD - 1)) begin
                    cnt_d = '0;
                    if (idx_q == CW'(FEAT_N - 1)) begin
                        state_d   = S_FILT;
                        idx_d     = '0;
                        feature_d = '0;
                        filter_d  = filt_data;
                    end else begin
                        idx_d     = idx_q + CW'(1);
                        feature_d = feat_data;
                    end
                end
            end
            S_FILT: begin
                if (cnt_q == CW'(HOLD - 1)) begin
                    cnt_d = '0;
                    if (idx_q == CW'(FILT_N - 1)) begin
                        state_d  = S_COLLECT;
                        idx_d    = '0;
                        filter_d = '0;
                    end else begin
                        idx_d    = idx_q + CW'(1);
                        filter_d = filt_data;
                    end
                end
            end
            S_COLLECT: begin
                // A completion seen on the last allowed cycle still wins over the timeout.
                if (cmpl_q || conv_complete) begin
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (cap_active && conv_done) begin
            if (count_q == (AW+1)'(MAX_OUT)) ovf_d = 1'b1;
            else                             count_d = count_q + (AW+1)'(1);
        end
        if (cap_active && conv_complete) cmpl_d = 1'b1;
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        job_done  = (state_q == S_DONE);
        conv_rst  = (state_q == S_IDLE) || (state_q == S_RESET) || (state_q == S_DONE);
        feat_rd   = 1'b0;
        feat_addr = '0;
        filt_rd   = 1'b0;
        filt_addr = '0;
        // Reads are issued two cycles ahead of the slot they feed.
        case (state_q)
            S_RESET: feat_rd = (cnt_q == CW'(RST_CYC - 2));
            S_FEAT: begin
                if (cnt_q == CW'(HOLD - 2)) begin
                    if (idx_q < CW'(FEAT_N - 1)) begin
                        feat_rd   = 1'b1;
                        feat_addr = AW'(idx_q + CW'(1));
                    end else begin
                        filt_rd   = 1'b1;
                    end
                end
            end
            S_FILT: begin
                if (cnt_q == CW'(HOLD - 2) && idx_q < CW'(FILT_N - 1)) begin
                    filt_rd   = 1'b1;
                    filt_addr = AW'(idx_q + CW'(1));
                end
            end
            default: ;
        endcase
        res_we   = cap_active && conv_done && (count_q < (AW+1)'(MAX_OUT));
        res_addr = count_q[AW-1:0];
        res_data = conv_out;
    end

    assign conv_feature = feature_q;
    assign conv_filter  = filter_q;
    assign conv_stride  = stride_q;
    assign conv_pad     = pad_q;
    assign res_count    = count_q;
    assign err_overflow = ovf_q;
    assign err_timeout  = tmo_q;

endmodule
